// File: rtl/hex_entry_pad.sv
// Hex keypad front end: debounced buttons build a 4*DIGITS-bit word one nibble
// at a time, then hand it to the CPU over a valid/ready handshake.
module hex_entry_pad #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DIGITS          = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [3:0]            SW,
    input  logic                  BtnDigit,
    input  logic                  BtnBack,
    input  logic                  BtnSend,
    input  logic                  data_ready,
    output logic [4*DIGITS-1:0]   data_out,
    output logic                  data_valid,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            digit_count,
    output logic                  busy
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int B_DIGIT = 0, B_BACK = 1, B_SEND = 2;

    typedef enum logic {EDIT, SEND} state_t;

    logic [2:0]         btn_raw;
    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]         deb_q, deb_d, press_q, press_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;

    state_t             state_q, state_d;
    logic [W-1:0]       entry_q, entry_d, data_out_q, data_out_d;
    logic [3:0]         digit_count_q, digit_count_d;
    logic               data_valid_q, data_valid_d;

    assign btn_raw = {BtnSend, BtnBack, BtnDigit};

    // Press pulse is registered on the same edge the debounced level rises,
    // so it appears in the first cycle the new level is visible.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = '0;
        cnt_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        digit_count_d = digit_count_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        case (state_q)
            EDIT: begin
                // Only the highest-priority pulse acts, even if it is itself ignored.
                if (press_q[B_SEND]) begin
                    if (digit_count_q != 4'd0) begin
                        data_out_d   = entry_q;
                        data_valid_d = 1'b1;
                        state_d      = SEND;
                    end
                end else if (press_q[B_BACK]) begin
                    if (digit_count_q != 4'd0) begin
                        entry_d       = entry_q >> 4;
                        digit_count_d = digit_count_q - 4'd1;
                    end
                end else if (press_q[B_DIGIT]) begin
                    if (digit_count_q < 4'(DIGITS)) begin
                        entry_d       = (entry_q << 4) | W'(SW);
                        digit_count_d = digit_count_q + 4'd1;
                    end
                end
            end
            SEND: begin
                if (data_valid_q && data_ready) begin
                    data_valid_d  = 1'b0;
                    entry_d       = '0;
                    digit_count_d = 4'd0;
                    state_d       = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            press_q       <= '0;
            cnt_q         <= '0;
            state_q       <= EDIT;
            entry_q       <= '0;
            digit_count_q <= 4'd0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            entry_q       <= entry_d;
            digit_count_q <= digit_count_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign entry       = entry_q;
    assign digit_count = digit_count_q;
    assign busy        = (state_q == SEND);
endmodule
